// File: rtl/aoi_2_1.sv
// aoi_2_1: 4x2 AND-OR-INVERT with combinational and registered results,
// registered product terms and a saturating count of registered-Y transitions.
`default_nettype none

module aoi_2_1 (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic       E,
   input  logic       F,
   input  logic       G,
   input  logic       H,
   input  logic       en,
   output logic       Y,
   output logic       Y_comb,
   output logic [3:0] term,
   output logic [7:0] toggle_cnt
);

   localparam logic [7:0] C_CNT_MAX = 8'hFF;

   logic [3:0] prod;
   logic       y_q,    y_d;
   logic [3:0] term_q, term_d;
   logic [7:0] cnt_q,  cnt_d;

   assign prod   = {G & H, E & F, C & D, A & B};
   assign Y_comb = ~|prod;

   always_comb begin
      y_d    = y_q;
      term_d = term_q;
      cnt_d  = cnt_q;
      if (en) begin
         y_d    = Y_comb;
         term_d = prod;
         // Count only real transitions of the registered output, pinned at max.
         if ((Y_comb != y_q) && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Reset value of Y is the AOI result for all-zero inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q    <= 1'b1;
         term_q <= 4'b0000;
         cnt_q  <= 8'd0;
      end else begin
         y_q    <= y_d;
         term_q <= term_d;
         cnt_q  <= cnt_d;
      end
   end

   assign Y          = y_q;
   assign term       = term_q;
   assign toggle_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aoi_2_1.sv
// tb_aoi_2_1: randomized and directed stimulus with a queued scoreboard for aoi_2_1.
`default_nettype none

module tb_aoi_2_1;

   logic       clk;
   logic       rst;
   logic       A, B, C, D, E, F, G, H;
   logic       en;
   logic       Y;
   logic       Y_comb;
   logic [3:0] term;
   logic [7:0] toggle_cnt;

   typedef struct packed {
      logic       y;
      logic [3:0] t;
      logic [7:0] c;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference state
   logic       m_y;
   logic [3:0] m_term;
   int         m_cnt;

   aoi_2_1 dut (
      .clk        (clk),
      .rst        (rst),
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .E          (E),
      .F          (F),
      .G          (G),
      .H          (H),
      .en         (en),
      .Y          (Y),
      .Y_comb     (Y_comb),
      .term       (term),
      .toggle_cnt (toggle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   // s[0]=A, s[1]=B, ... s[7]=H ; pair i is (s[2i], s[2i+1])
   function automatic logic [3:0] ref_terms(input logic [7:0] s);
      logic [3:0] t;
      for (int i = 0; i < 4; i++) t[i] = s[2*i] && s[2*i+1];
      return t;
   endfunction

   function automatic logic ref_aoi(input logic [7:0] s);
      int ones = 0;
      for (int i = 0; i < 4; i++) if (s[2*i] && s[2*i+1]) ones++;
      return (ones == 0);
   endfunction

   task automatic model_reset();
      m_y    = 1'b1;
      m_term = 4'b0000;
      m_cnt  = 0;
   endtask

   task automatic drive(input logic [7:0] s, input logic e);
      exp_t x;
      @(negedge clk);
      {H, G, F, E, D, C, B, A} = s;
      en = e;
      #1;
      chk("y_comb", {31'd0, Y_comb}, {31'd0, ref_aoi(s)});
      if (e) begin
         if (ref_aoi(s) != m_y && m_cnt < 255) m_cnt = m_cnt + 1;
         m_y    = ref_aoi(s);
         m_term = ref_terms(s);
      end
      x.y = m_y;
      x.t = m_term;
      x.c = m_cnt[7:0];
      exp_q.push_back(x);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_y"},    {31'd0, Y},          32'd1);
      chk({tag, "_term"}, {28'd0, term},       32'd0);
      chk({tag, "_cnt"},  {24'd0, toggle_cnt}, 32'd0);
   endtask

   // Mid-cycle asynchronous reset, away from any clock edge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      en  = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_vals("async_rst");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: registered outputs are valid one cycle after each issued stimulus.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk("y_reg",  {31'd0, Y},          {31'd0, x.y});
         chk("term",   {28'd0, term},       {28'd0, x.t});
         chk("tog_cnt", {24'd0, toggle_cnt}, {24'd0, x.c});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      {H, G, F, E, D, C, B, A} = 8'h00;
      model_reset();
      #12;
      check_reset_vals("reset");
      chk("reset_ycomb", {31'd0, Y_comb}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // all zero then all ones
      drive(8'h00, 1'b1);
      drive(8'hFF, 1'b1);

      // C=D=1 held off by en=0, then loaded
      drive(8'h00, 1'b1);
      repeat (3) drive(8'h0C, 1'b0);
      drive(8'h0C, 1'b1);

      // exhaustive sweep
      for (int v = 0; v < 256; v++) drive(v[7:0], 1'b1);

      // random with random enable
      repeat (200) drive($urandom_range(0, 255), $urandom_range(0, 3) != 0);

      // reach Y=0, toggle_cnt=5 then reset between edges
      async_reset();
      drive(8'h00, 1'b1);
      for (int k = 0; k < 5; k++) drive((k % 2 == 0) ? 8'h03 : 8'h00, 1'b1);
      async_reset();

      // saturation
      for (int k = 0; k < 300; k++) drive((k % 2 == 0) ? 8'h03 : 8'h00, 1'b1);
      @(posedge clk);
      #2;
      chk("sat_cnt", {24'd0, toggle_cnt}, 32'd255);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
